// File: rtl/systolic_mm_tile_if.sv
// Operand/result stream bundle for the systolic matrix-multiply tile.
// The master side feeds jobs and operand beats; the slave side is the tile.
interface systolic_mm_tile_if #(
  parameter int N      = 8,
  parameter int DATA_W = 8,
  parameter int K_W    = 8,
  parameter int ACC_W  = 2*DATA_W + K_W
);
  logic                             start;
  logic [K_W-1:0]                   k_len;
  logic                             in_valid;
  logic                             in_ready;
  logic [N-1:0][DATA_W-1:0]         a_vec;
  logic [N-1:0][DATA_W-1:0]         b_vec;
  logic                             busy;
  logic                             out_valid;
  logic                             out_ready;
  logic [N-1:0][N-1:0][ACC_W-1:0]   c;

  modport master (
    output start, k_len, in_valid, a_vec, b_vec, out_ready,
    input  in_ready, busy, out_valid, c
  );

  modport slave (
    input  start, k_len, in_valid, a_vec, b_vec, out_ready,
    output in_ready, busy, out_valid, c
  );
endinterface

// File: rtl/systolic_mm_tile.sv
// NxN output-stationary systolic matrix-multiply tile: skews unskewed operand beats,
// accumulates C = A*B in place, drains for 2N-1 cycles and holds C until handed off.
module systolic_mm_tile #(
  parameter int N      = 8,
  parameter int DATA_W = 8,
  parameter int K_W    = 8,
  parameter int ACC_W  = 2*DATA_W + K_W,
  parameter bit SIGNED = 1'b0
) (
  input logic               clk,
  input logic               rst,
  systolic_mm_tile_if.slave bus
);

  localparam int DRAIN_LEN = 2*N - 1;
  localparam int DC_W      = $clog2(2*N);
  localparam int PROD_W    = 2*DATA_W;

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

  state_t            state, state_next;
  logic [K_W-1:0]    k_len_q;
  logic [K_W-1:0]    beat_cnt;
  logic [DC_W-1:0]   drain_cnt;
  logic              clear;
  logic              beat;
  logic              last_beat;
  logic              drain_done;
  logic              acc_en;

  logic [DATA_W-1:0] a_edge   [N];
  logic [DATA_W-1:0] b_edge   [N];
  logic [DATA_W-1:0] pe_a_in  [N][N];
  logic [DATA_W-1:0] pe_b_in  [N][N];
  logic [DATA_W-1:0] a_pipe   [N][N];
  logic [DATA_W-1:0] b_pipe   [N][N];
  logic [ACC_W-1:0]  prod     [N][N];
  logic [ACC_W-1:0]  acc      [N][N];

  assign clear      = (state == IDLE) && bus.start;
  assign beat       = (state == LOAD) && bus.in_valid;
  assign last_beat  = beat && (beat_cnt == (k_len_q - K_W'(1)));
  assign drain_done = (drain_cnt == DC_W'(DRAIN_LEN - 1));
  assign acc_en     = (state == LOAD) || (state == DRAIN);

  assign bus.in_ready  = (state == LOAD);
  assign bus.busy      = (state != IDLE);
  assign bus.out_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (bus.start) state_next = (bus.k_len == '0) ? DONE : LOAD;
      LOAD:  if (last_beat) state_next = DRAIN;
      DRAIN: if (drain_done) state_next = DONE;
      DONE:  if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k_len_q   <= '0;
      beat_cnt  <= '0;
      drain_cnt <= '0;
    end else begin
      if (clear) begin
        k_len_q  <= bus.k_len;
        beat_cnt <= '0;
      end else if (beat) begin
        beat_cnt <= beat_cnt + K_W'(1);
      end
      drain_cnt <= (state == DRAIN) ? drain_cnt + DC_W'(1) : '0;
    end
  end

  // Idle/stall cycles feed zeros, so the result does not depend on the valid pattern.
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [DATA_W-1:0] feed_a, feed_b;
    assign feed_a = beat ? bus.a_vec[i] : '0;
    assign feed_b = beat ? bus.b_vec[i] : '0;

    if (i == 0) begin : g_direct
      assign a_edge[i] = feed_a;
      assign b_edge[i] = feed_b;
    end else begin : g_delay
      logic [DATA_W-1:0] a_sr [i];
      logic [DATA_W-1:0] b_sr [i];

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int d = 0; d < i; d++) begin
            a_sr[d] <= '0;
            b_sr[d] <= '0;
          end
        end else if (clear) begin
          for (int d = 0; d < i; d++) begin
            a_sr[d] <= '0;
            b_sr[d] <= '0;
          end
        end else begin
          a_sr[0] <= feed_a;
          b_sr[0] <= feed_b;
          for (int d = 1; d < i; d++) begin
            a_sr[d] <= a_sr[d-1];
            b_sr[d] <= b_sr[d-1];
          end
        end
      end

      assign a_edge[i] = a_sr[i-1];
      assign b_edge[i] = b_sr[i-1];
    end
  end

  function automatic logic [ACC_W-1:0] mul_ext(input logic [DATA_W-1:0] x,
                                               input logic [DATA_W-1:0] y);
    logic signed [PROD_W-1:0] xs, ys, p;
    if (SIGNED) begin
      xs = $signed({{DATA_W{x[DATA_W-1]}}, x});
      ys = $signed({{DATA_W{y[DATA_W-1]}}, y});
      p  = xs * ys;
      return ACC_W'(p);
    end else begin
      xs = $signed({{DATA_W{1'b0}}, x});
      ys = $signed({{DATA_W{1'b0}}, y});
      p  = xs * ys;
      return ACC_W'($unsigned(p));
    end
  endfunction

  always_comb begin
    for (int i = 0; i < N; i++) begin
      pe_a_in[i][0] = a_edge[i];
      for (int j = 1; j < N; j++) pe_a_in[i][j] = a_pipe[i][j-1];
    end
    for (int j = 0; j < N; j++) begin
      pe_b_in[0][j] = b_edge[j];
      for (int i = 1; i < N; i++) pe_b_in[i][j] = b_pipe[i-1][j];
    end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        prod[i][j] = mul_ext(pe_a_in[i][j], pe_b_in[i][j]);
  end

  // A flows right, B flows down; accumulators only move in LOAD/DRAIN so C is frozen afterwards.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          a_pipe[i][j] <= '0;
          b_pipe[i][j] <= '0;
          acc[i][j]    <= '0;
        end
    end else if (clear) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          a_pipe[i][j] <= '0;
          b_pipe[i][j] <= '0;
          acc[i][j]    <= '0;
        end
    end else begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          a_pipe[i][j] <= pe_a_in[i][j];
          b_pipe[i][j] <= pe_b_in[i][j];
          if (acc_en) acc[i][j] <= acc[i][j] + prod[i][j];
        end
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        bus.c[i][j] = acc[i][j];
  end

endmodule

// File: tb/tb_systolic_mm_tile.sv
// Directed bench for systolic_mm_tile: a 3x3 unsigned tile for protocol/timing,
// plus 8x8 signed/unsigned and a 16-bit-accumulator 2x2 tile for arithmetic corners.
module tb_systolic_mm_tile;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int check_count = 0;
  int error_count = 0;

  systolic_mm_tile_if #(.N(3))              bus3  ();
  systolic_mm_tile_if #(.N(8))              bus8s ();
  systolic_mm_tile_if #(.N(8))              bus8u ();
  systolic_mm_tile_if #(.N(2), .ACC_W(16))  bus16 ();

  systolic_mm_tile #(.N(3), .SIGNED(1'b0))              dut3  (.clk(clk), .rst(rst), .bus(bus3));
  systolic_mm_tile #(.N(8), .SIGNED(1'b1))              dut8s (.clk(clk), .rst(rst), .bus(bus8s));
  systolic_mm_tile #(.N(8), .SIGNED(1'b0))              dut8u (.clk(clk), .rst(rst), .bus(bus8u));
  systolic_mm_tile #(.N(2), .ACC_W(16), .SIGNED(1'b0))  dut16 (.clk(clk), .rst(rst), .bus(bus16));

  int mat_a [3][3] = '{'{1, 2, 3}, '{4, 5, 6}, '{7, 8, 9}};
  int mat_b [3][3] = '{'{10, 11, 12}, '{13, 14, 15}, '{16, 17, 18}};
  int mat_c [3][3] = '{'{84, 90, 96}, '{201, 216, 231}, '{318, 342, 366}};

  task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
    check_count++;
    if (got !== exp) begin
      error_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // All tasks enter and leave 1 time unit after a rising edge.
  task automatic start_job3(input int k);
    bus3.start = 1'b1;
    bus3.k_len = 8'(k);
    tick();
    bus3.start = 1'b0;
  endtask

  task automatic feed3(input bit stall, input string tag);
    int  k   = 0;
    int  cyc = 0;
    bit  took;
    while (k < 3 && cyc < 40) begin
      bus3.in_valid = stall ? (cyc % 2 == 0) : 1'b1;
      for (int i = 0; i < 3; i++) begin
        bus3.a_vec[i] = 8'(mat_a[i][k]);
        bus3.b_vec[i] = 8'(mat_b[k][i]);
      end
      took = bus3.in_valid && bus3.in_ready;
      tick();
      if (took) k++;
      cyc++;
    end
    bus3.in_valid = 1'b0;
    bus3.a_vec    = '0;
    bus3.b_vec    = '0;
    check_output({tag, " beats accepted"}, 64'(k), 64'd3);
  endtask

  task automatic wait_done3(output int n);
    n = 0;
    while (!bus3.out_valid && n < 50) begin
      tick();
      n++;
    end
  endtask

  task automatic check_c3(input string tag);
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        check_output($sformatf("%s c[%0d][%0d]", tag, i, j), 64'(bus3.c[i][j]), 64'(mat_c[i][j]));
  endtask

  task automatic handoff3(input string tag);
    bus3.out_ready = 1'b1;
    tick();
    bus3.out_ready = 1'b0;
    check_output({tag, " busy after handoff"}, 64'(bus3.busy), 64'd0);
    check_output({tag, " out_valid after handoff"}, 64'(bus3.out_valid), 64'd0);
  endtask

  task automatic apply_stimulus(input logic [7:0] sa, input logic [7:0] sb, input logic [63:0] exp_s,
                                input logic [7:0] ua, input logic [7:0] ub, input logic [63:0] exp_u,
                                input logic [63:0] exp16, input string tag);
    int n = 0;
    bus8s.a_vec = {8{sa}};  bus8s.b_vec = {8{sb}};
    bus8u.a_vec = {8{ua}};  bus8u.b_vec = {8{ub}};
    bus16.a_vec = {2{ua}};  bus16.b_vec = {2{ub}};
    bus8s.k_len = 8'd4;  bus8u.k_len = 8'd4;  bus16.k_len = 8'd2;
    bus8s.start = 1'b1;  bus8u.start = 1'b1;  bus16.start = 1'b1;
    tick();
    bus8s.start = 1'b0;  bus8u.start = 1'b0;  bus16.start = 1'b0;
    bus8s.in_valid = 1'b1;  bus8u.in_valid = 1'b1;  bus16.in_valid = 1'b1;
    while (!(bus8s.out_valid && bus8u.out_valid && bus16.out_valid) && n < 60) begin
      tick();
      n++;
    end
    bus8s.in_valid = 1'b0;  bus8u.in_valid = 1'b0;  bus16.in_valid = 1'b0;
    check_output({tag, " 8s out_valid"}, 64'(bus8s.out_valid), 64'd1);
    check_output({tag, " 8u out_valid"}, 64'(bus8u.out_valid), 64'd1);
    check_output({tag, " 16 out_valid"}, 64'(bus16.out_valid), 64'd1);
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        check_output($sformatf("%s 8s c[%0d][%0d]", tag, i, j), 64'(bus8s.c[i][j]), exp_s);
        check_output($sformatf("%s 8u c[%0d][%0d]", tag, i, j), 64'(bus8u.c[i][j]), exp_u);
      end
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++)
        check_output($sformatf("%s 16 c[%0d][%0d]", tag, i, j), 64'(bus16.c[i][j]), exp16);
    bus8s.out_ready = 1'b1;  bus8u.out_ready = 1'b1;  bus16.out_ready = 1'b1;
    tick();
    bus8s.out_ready = 1'b0;  bus8u.out_ready = 1'b0;  bus16.out_ready = 1'b0;
    check_output({tag, " 8s busy after handoff"}, 64'(bus8s.busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    bus3.start = 1'b0;   bus3.k_len = '0;   bus3.in_valid = 1'b0;   bus3.out_ready = 1'b0;
    bus3.a_vec = '0;     bus3.b_vec = '0;
    bus8s.start = 1'b0;  bus8s.k_len = '0;  bus8s.in_valid = 1'b0;  bus8s.out_ready = 1'b0;
    bus8s.a_vec = '0;    bus8s.b_vec = '0;
    bus8u.start = 1'b0;  bus8u.k_len = '0;  bus8u.in_valid = 1'b0;  bus8u.out_ready = 1'b0;
    bus8u.a_vec = '0;    bus8u.b_vec = '0;
    bus16.start = 1'b0;  bus16.k_len = '0;  bus16.in_valid = 1'b0;  bus16.out_ready = 1'b0;
    bus16.a_vec = '0;    bus16.b_vec = '0;

    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    tick();

    $display("[TB] reset state");
    check_output("reset in_ready", 64'(bus3.in_ready), 64'd0);
    check_output("reset busy", 64'(bus3.busy), 64'd0);
    check_output("reset out_valid", 64'(bus3.out_valid), 64'd0);
    check_output("reset c[1][2]", 64'(bus3.c[1][2]), 64'd0);

    $display("[TB] 3x3 job, continuous valid");
    start_job3(3);
    check_output("t1 in_ready in LOAD", 64'(bus3.in_ready), 64'd1);
    check_output("t1 busy in LOAD", 64'(bus3.busy), 64'd1);
    feed3(1'b0, "t1");
    wait_done3(n);
    check_output("t1 drain latency", 64'(n), 64'd5);
    check_c3("t1");
    handoff3("t1");
    check_output("t1 c held after handoff", 64'(bus3.c[1][1]), 64'd216);

    $display("[TB] 3x3 job, valid toggling");
    start_job3(3);
    feed3(1'b1, "t2");
    wait_done3(n);
    check_output("t2 drain latency", 64'(n), 64'd5);
    check_c3("t2");
    handoff3("t2");

    $display("[TB] k_len = 0 job");
    start_job3(0);
    check_output("k0 out_valid", 64'(bus3.out_valid), 64'd1);
    check_output("k0 c[0][0]", 64'(bus3.c[0][0]), 64'd0);
    check_output("k0 c[2][2]", 64'(bus3.c[2][2]), 64'd0);
    handoff3("k0");

    $display("[TB] backpressure in DONE");
    start_job3(3);
    feed3(1'b0, "t5");
    wait_done3(n);
    for (int cyc = 0; cyc < 10; cyc++) begin
      bus3.start = (cyc == 3);
      bus3.k_len = 8'd3;
      tick();
      check_output("t5 out_valid held", 64'(bus3.out_valid), 64'd1);
      check_output("t5 busy held", 64'(bus3.busy), 64'd1);
      check_output("t5 c[0][0] stable", 64'(bus3.c[0][0]), 64'd84);
      check_output("t5 c[2][2] stable", 64'(bus3.c[2][2]), 64'd366);
    end
    bus3.start = 1'b0;
    handoff3("t5");
    check_output("t5 c kept after ignored start", 64'(bus3.c[0][1]), 64'd90);

    $display("[TB] reset during LOAD");
    start_job3(3);
    bus3.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus3.a_vec[i] = 8'(mat_a[i][0]);
      bus3.b_vec[i] = 8'(mat_b[0][i]);
    end
    tick();
    check_output("t6 partial c[0][0]", 64'(bus3.c[0][0]), 64'd10);
    for (int i = 0; i < 3; i++) begin
      bus3.a_vec[i] = 8'(mat_a[i][1]);
      bus3.b_vec[i] = 8'(mat_b[1][i]);
    end
    #2;
    rst = 1'b0;
    #1;
    check_output("t6 in_ready in reset", 64'(bus3.in_ready), 64'd0);
    check_output("t6 busy in reset", 64'(bus3.busy), 64'd0);
    check_output("t6 out_valid in reset", 64'(bus3.out_valid), 64'd0);
    check_output("t6 c[0][0] in reset", 64'(bus3.c[0][0]), 64'd0);
    bus3.in_valid = 1'b0;
    bus3.a_vec    = '0;
    bus3.b_vec    = '0;
    @(negedge clk);
    rst = 1'b1;
    tick();
    check_output("t6 busy after release", 64'(bus3.busy), 64'd0);
    start_job3(3);
    feed3(1'b0, "t6");
    wait_done3(n);
    check_output("t6 drain latency", 64'(n), 64'd5);
    check_c3("t6");
    handoff3("t6");

    $display("[TB] wide tiles, constant operands");
    // -128*-128*4 = 65536; 255*255*4 = 260100; 255*255*2 mod 2^16 = 64514
    apply_stimulus(8'h80, 8'h80, 64'd65536, 8'hFF, 8'hFF, 64'd260100, 64'd64514, "w1");
    // -128*127*4 = -65024 -> 16712192 in 24 bits; 255*1*4 = 1020; 255*1*2 = 510
    apply_stimulus(8'h80, 8'h7F, 64'd16712192, 8'hFF, 8'h01, 64'd1020, 64'd510, "w2");

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
